// File: rtl/pifo_pop_checker_if.sv
// Request/return bundle of one PIFO push/pop lane as seen by its checker.
interface pifo_pop_checker_if #(
    parameter int PTW           = 16,
    parameter int TREE_NUM_BITS = 4
);
    logic                     i_push;
    logic [PTW-1:0]           i_push_data;
    logic [TREE_NUM_BITS-1:0] i_tree_id;
    logic                     i_pop;
    logic [PTW-1:0]           i_pop_data;
    logic                     i_task_fifo_full;

    modport master (
        output i_push, i_push_data, i_tree_id, i_pop, i_pop_data, i_task_fifo_full
    );

    modport slave (
        input  i_push, i_push_data, i_tree_id, i_pop, i_pop_data, i_task_fifo_full
    );
endinterface

// File: rtl/pifo_pop_checker.sv
// Per-lane PIFO monitor: occupancy, pop/return alignment, error flags and counters.
// Order checking is built only when PIFO_CHK_ORDER_EN is defined.
module pifo_pop_checker #(
    parameter int PTW           = 16,
    parameter int TREE_NUM      = 10,
    parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
    parameter int CAP           = 62,
    parameter int POP_LAT       = 2,
    parameter int CNT_W         = 16
) (
    input  logic                     i_clk,
    input  logic                     i_srst,
    pifo_pop_checker_if.slave        bus,
    output logic                     o_err_underflow,
    output logic                     o_err_overflow,
    output logic                     o_err_tree,
    output logic                     o_err_order,
    output logic                     o_err_sticky,
    output logic [1:0]               o_first_err_code,
    output logic [TREE_NUM_BITS-1:0] o_first_err_tree,
    output logic [CNT_W-1:0]         o_pop_cnt,
    output logic [CNT_W-1:0]         o_err_cnt
);
    localparam int OCC_W = $clog2(CAP + 1);

    logic [OCC_W-1:0]         r_occ     [TREE_NUM];
    logic                     r_stg_v   [POP_LAT];
    logic [TREE_NUM_BITS-1:0] r_stg_tree[POP_LAT];

    logic                     w_tid_ok;
    logic [TREE_NUM_BITS-1:0] w_tid;
    logic [OCC_W-1:0]         w_occ;
    logic                     w_uf, w_of, w_te, w_oe;
    logic                     w_inc, w_dec;
    logic                     w_ret_v;
    logic [TREE_NUM_BITS-1:0] w_ret_tree;
    logic [2:0]               w_nerr;
    logic [CNT_W:0]           w_err_sum;
    logic [1:0]               w_code;
    logic [TREE_NUM_BITS-1:0] w_etree;

    always_comb begin
        w_tid_ok   = 32'(bus.i_tree_id) < 32'(TREE_NUM);
        w_tid      = w_tid_ok ? bus.i_tree_id : '0;
        w_occ      = r_occ[w_tid];
        // push and pop both judge against the pre-cycle occupancy
        w_uf       = bus.i_pop  && w_tid_ok && (w_occ == '0);
        w_of       = bus.i_push && w_tid_ok &&
                     ((w_occ == OCC_W'(CAP)) || bus.i_task_fifo_full);
        w_te       = (bus.i_push || bus.i_pop) && !w_tid_ok;
        w_inc      = bus.i_push && w_tid_ok && !w_of;
        w_dec      = bus.i_pop  && w_tid_ok && !w_uf;
        w_ret_v    = r_stg_v[POP_LAT-1];
        w_ret_tree = r_stg_tree[POP_LAT-1];
        w_nerr     = 3'(w_uf) + 3'(w_of) + 3'(w_te) + 3'(w_oe);
        w_err_sum  = {1'b0, o_err_cnt} + (CNT_W+1)'(w_nerr);
        w_code     = w_uf ? 2'd0 : (w_of ? 2'd1 : (w_te ? 2'd2 : 2'd3));
        w_etree    = (w_uf || w_of || w_te) ? bus.i_tree_id : w_ret_tree;
    end

`ifdef PIFO_CHK_ORDER_EN
    logic [PTW-1:0]      r_last [TREE_NUM];
    logic [TREE_NUM-1:0] r_last_v;

    assign w_oe = w_ret_v && r_last_v[w_ret_tree] && (bus.i_pop_data < r_last[w_ret_tree]);

    // a new push may carry a smaller priority, so it invalidates the reference
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_last_v <= '0;
        end else begin
            if (w_ret_v)
                r_last_v[w_ret_tree] <= 1'b1;
            if (bus.i_push && w_tid_ok)
                r_last_v[w_tid] <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_srst && w_ret_v)
            r_last[w_ret_tree] <= bus.i_pop_data;
    end
`else
    logic w_unused_pop_data;

    assign w_oe              = 1'b0;
    assign w_unused_pop_data = ^bus.i_pop_data;
`endif

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            for (int unsigned t = 0; t < TREE_NUM; t++)
                r_occ[t] <= '0;
            for (int unsigned k = 0; k < POP_LAT; k++) begin
                r_stg_v[k]    <= 1'b0;
                r_stg_tree[k] <= '0;
            end
            o_err_underflow  <= 1'b0;
            o_err_overflow   <= 1'b0;
            o_err_tree       <= 1'b0;
            o_err_order      <= 1'b0;
            o_err_sticky     <= 1'b0;
            o_first_err_code <= '0;
            o_first_err_tree <= '0;
            o_pop_cnt        <= '0;
            o_err_cnt        <= '0;
        end else begin
            if (w_inc && !w_dec)
                r_occ[w_tid] <= w_occ + OCC_W'(1);
            else if (w_dec && !w_inc)
                r_occ[w_tid] <= w_occ - OCC_W'(1);

            r_stg_v[0]    <= w_dec;
            r_stg_tree[0] <= w_tid;
            for (int unsigned k = 1; k < POP_LAT; k++) begin
                r_stg_v[k]    <= r_stg_v[k-1];
                r_stg_tree[k] <= r_stg_tree[k-1];
            end

            o_err_underflow <= w_uf;
            o_err_overflow  <= w_of;
            o_err_tree      <= w_te;
            o_err_order     <= w_oe;

            if (w_nerr != '0) begin
                o_err_sticky <= 1'b1;
                if (!o_err_sticky) begin
                    o_first_err_code <= w_code;
                    o_first_err_tree <= w_etree;
                end
            end

            o_err_cnt <= w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
            if (w_ret_v && (o_pop_cnt != '1))
                o_pop_cnt <= o_pop_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pifo_pop_checker.sv
// Directed bench for pifo_pop_checker (POP_LAT=2, CAP=62, TREE_NUM=10).
module tb_pifo_pop_checker;
    logic        clk;
    logic        srst;
    logic        err_uf, err_of, err_tree, err_order, err_sticky;
    logic [1:0]  first_code;
    logic [3:0]  first_tree;
    logic [15:0] pop_cnt, err_cnt;

    int vectors     = 0;
    int miscompares = 0;

    pifo_pop_checker_if #(.PTW(16), .TREE_NUM_BITS(4)) bus ();

    pifo_pop_checker #(
        .PTW(16), .TREE_NUM(10), .TREE_NUM_BITS(4), .CAP(62), .POP_LAT(2), .CNT_W(16)
    ) dut (
        .i_clk(clk), .i_srst(srst), .bus(bus.slave),
        .o_err_underflow(err_uf), .o_err_overflow(err_of), .o_err_tree(err_tree),
        .o_err_order(err_order), .o_err_sticky(err_sticky),
        .o_first_err_code(first_code), .o_first_err_tree(first_tree),
        .o_pop_cnt(pop_cnt), .o_err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive one cycle of stimulus, then sample 1 time unit after the edge
    task automatic step(input logic push, input logic [15:0] pd, input logic [3:0] tid,
                        input logic pop, input logic [15:0] popd, input logic full);
        bus.i_push = push; bus.i_push_data = pd; bus.i_tree_id = tid;
        bus.i_pop = pop; bus.i_pop_data = popd; bus.i_task_fifo_full = full;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [15:0] popd);
        step(1'b0, 16'd0, 4'd0, 1'b0, popd, 1'b0);
    endtask

    task automatic do_reset();
        srst = 1'b1;
        idle(16'd0);
        idle(16'd0);
        srst = 1'b0;
    endtask

    initial begin
        srst = 1'b1;
        bus.i_push = 0; bus.i_push_data = 0; bus.i_tree_id = 0;
        bus.i_pop = 0; bus.i_pop_data = 0; bus.i_task_fifo_full = 0;
        do_reset();

        chk("rst_uf", err_uf, 0);
        chk("rst_of", err_of, 0);
        chk("rst_tree", err_tree, 0);
        chk("rst_order", err_order, 0);
        chk("rst_sticky", err_sticky, 0);
        chk("rst_code", first_code, 0);
        chk("rst_ftree", first_tree, 0);
        chk("rst_popcnt", pop_cnt, 0);
        chk("rst_errcnt", err_cnt, 0);

        // fill tree 0 to capacity, drain back-to-back with returns two cycles behind
        for (int i = 0; i < 62; i++)
            step(1'b1, 16'(i), 4'd0, 1'b0, 16'd0, 1'b0);
        for (int k = 0; k < 64; k++)
            step(1'b0, 16'd0, 4'd0, k < 62, (k >= 2) ? 16'(k - 2) : 16'd0, 1'b0);
        chk("fill_sticky", err_sticky, 0);
        chk("fill_errcnt", err_cnt, 0);
        chk("fill_popcnt", pop_cnt, 62);
        step(1'b0, 16'd0, 4'd0, 1'b1, 16'd0, 1'b0);
        chk("drain_empty_uf", err_uf, 1);
        do_reset();

        // underflow on tree 3; its return slot must not be counted
        step(1'b0, 16'd0, 4'd3, 1'b1, 16'd0, 1'b0);
        chk("uf_pulse", err_uf, 1);
        chk("uf_code", first_code, 0);
        chk("uf_tree", first_tree, 3);
        chk("uf_errcnt", err_cnt, 1);
        chk("uf_sticky", err_sticky, 1);
        idle(16'd0);
        chk("uf_pulse_end", err_uf, 0);
        idle(16'h00ff);
        chk("uf_no_popcnt", pop_cnt, 0);
        chk("uf_no_order", err_order, 0);
        do_reset();

        // overflow: full tree, then task FIFO full on an empty tree
        for (int i = 0; i < 62; i++)
            step(1'b1, 16'(i), 4'd7, 1'b0, 16'd0, 1'b0);
        chk("of_none_at_cap", err_sticky, 0);
        step(1'b1, 16'd99, 4'd7, 1'b0, 16'd0, 1'b0);
        chk("of_pulse", err_of, 1);
        chk("of_code", first_code, 1);
        chk("of_tree", first_tree, 7);
        chk("of_errcnt", err_cnt, 1);
        step(1'b1, 16'd1, 4'd2, 1'b0, 16'd0, 1'b1);
        chk("of_full_pulse", err_of, 1);
        chk("of_full_errcnt", err_cnt, 2);
        chk("of_first_hold", first_tree, 7);
        do_reset();

        // order: returns 9 then 5 on tree 1
        step(1'b1, 16'd5, 4'd1, 1'b0, 16'd0, 1'b0);
        step(1'b1, 16'd9, 4'd1, 1'b0, 16'd0, 1'b0);
        step(1'b0, 16'd0, 4'd1, 1'b1, 16'd0, 1'b0);
        step(1'b0, 16'd0, 4'd1, 1'b1, 16'd0, 1'b0);
        idle(16'd9);
        chk("ord_first_ok", err_order, 0);
        chk("ord_popcnt1", pop_cnt, 1);
        idle(16'd5);
        chk("ord_popcnt2", pop_cnt, 2);
`ifdef PIFO_CHK_ORDER_EN
        chk("ord_pulse", err_order, 1);
        chk("ord_code", first_code, 3);
        chk("ord_tree", first_tree, 1);
        chk("ord_errcnt", err_cnt, 1);
`else
        chk("ord_off_pulse", err_order, 0);
        chk("ord_off_sticky", err_sticky, 0);
`endif
        idle(16'd0);
        chk("ord_pulse_end", err_order, 0);
        do_reset();

        // same-cycle push+pop at occ 0, then bad tree id
        step(1'b1, 16'd4, 4'd4, 1'b1, 16'd0, 1'b0);
        chk("sc_uf", err_uf, 1);
        chk("sc_of", err_of, 0);
        chk("sc_tree", first_tree, 4);
        step(1'b0, 16'd0, 4'd4, 1'b1, 16'd0, 1'b0);
        chk("sc_occ1_pop_ok", err_uf, 0);
        step(1'b0, 16'd0, 4'd4, 1'b1, 16'd0, 1'b0);
        chk("sc_occ0_uf", err_uf, 1);
        step(1'b1, 16'd0, 4'd12, 1'b0, 16'd4, 1'b0);
        chk("bad_id_pulse", err_tree, 1);
        chk("bad_id_errcnt", err_cnt, 3);
        chk("sc_popcnt", pop_cnt, 1);
        chk("bad_id_code_hold", first_code, 0);
        do_reset();

        // reset while a return is in flight
        step(1'b1, 16'd0, 4'd13, 1'b0, 16'd0, 1'b0);
        step(1'b1, 16'd3, 4'd5, 1'b0, 16'd0, 1'b0);
        step(1'b0, 16'd0, 4'd5, 1'b1, 16'd0, 1'b0);
        chk("mid_sticky_pre", err_sticky, 1);
        srst = 1'b1;
        idle(16'd0);
        srst = 1'b0;
        chk("mid_sticky", err_sticky, 0);
        chk("mid_errcnt", err_cnt, 0);
        chk("mid_ftree", first_tree, 0);
        idle(16'd3);
        chk("mid_stale_popcnt", pop_cnt, 0);
        idle(16'd3);
        chk("mid_stale_popcnt2", pop_cnt, 0);
        chk("mid_order", err_order, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
